// File: rtl/clock_pulse_monitor.sv
// Monitors a divided clock sampled in the clk_in domain. It produces edge strobes, measures period and high time,
// and reports lock, err and stall. Strobes follow div_in by three clk_in edges. All outputs are registered.
module clock_pulse_monitor #(
  parameter int CNT_W      = 8,
  parameter int EXP_PERIOD = 5,
  parameter int LOCK_COUNT = 4
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             div_in,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic             period_valid,
  output logic             lock,
  output logic             err,
  output logic             stall
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] EXP_CNT = CNT_W'(EXP_PERIOD);
  localparam logic [3:0]       LOCK_N  = 4'(LOCK_COUNT);

  typedef enum logic [1:0] {IDLE, ARMED, TRACK} state_t;

  state_t           state;
  logic             s1, s2, s3;
  logic             rise, fall;
  logic [CNT_W-1:0] pcnt, hcnt;
  logic [3:0]       mcnt;

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      s1           <= 1'b0;
      s2           <= 1'b0;
      s3           <= 1'b0;
      pcnt         <= '0;
      hcnt         <= '0;
      mcnt         <= '0;
      state        <= IDLE;
      rise_pulse   <= 1'b0;
      fall_pulse   <= 1'b0;
      period_cnt   <= '0;
      high_cnt     <= '0;
      period_valid <= 1'b0;
      lock         <= 1'b0;
      err          <= 1'b0;
      stall        <= 1'b0;
    end else begin
      s1           <= div_in;
      s2           <= s1;
      s3           <= s2;
      rise_pulse   <= rise;
      fall_pulse   <= fall;
      period_valid <= 1'b0;
      err          <= 1'b0;

      if (rise)
        hcnt <= CNT_ONE;
      else if (s2 && hcnt != CNT_MAX)
        hcnt <= hcnt + CNT_ONE;
      if (fall)
        high_cnt <= hcnt;

      case (state)
        IDLE: begin
          if (rise) begin
            pcnt  <= CNT_ONE;
            state <= ARMED;
            stall <= 1'b0;
          end else begin
            pcnt  <= '0;
          end
        end
        // ARMED holds the first reference edge. Whatever preceded that edge is discarded.
        // A timeout before the first full period returns to IDLE silently.
        ARMED, TRACK: begin
          if (rise) begin
            pcnt         <= CNT_ONE;
            state        <= TRACK;
            period_cnt   <= pcnt;
            period_valid <= 1'b1;
            if (pcnt == EXP_CNT) begin
              if (mcnt != LOCK_N)
                mcnt <= mcnt + 4'd1;
              if (mcnt >= LOCK_N - 4'd1)
                lock <= 1'b1;
            end else begin
              err  <= 1'b1;
              mcnt <= '0;
              lock <= 1'b0;
            end
          end else if (pcnt == CNT_MAX) begin
            pcnt  <= '0;
            state <= IDLE;
            if (state == TRACK) begin
              stall <= 1'b1;
              lock  <= 1'b0;
              mcnt  <= '0;
            end
          end else begin
            pcnt <= pcnt + CNT_ONE;
          end
        end
        default: begin
          pcnt  <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_pulse_monitor.sv
// Randomized bench for clock_pulse_monitor: an edge-timestamp reference model is compared every cycle,
// and directed phases pin the model with hand-computed values.
module tb_clock_pulse_monitor;

  localparam int CNT_W = 8;
  localparam int EXP   = 5;
  localparam int LOCKN = 4;
  localparam int CMAX  = 255;
  localparam int NREC  = 2048;

  logic             clk_in, rst, div_in;
  logic             rise_pulse, fall_pulse, period_valid, lock, err, stall;
  logic [CNT_W-1:0] period_cnt, high_cnt;

  clock_pulse_monitor #(.CNT_W(CNT_W), .EXP_PERIOD(EXP), .LOCK_COUNT(LOCKN)) dut (
    .clk_in       (clk_in),
    .rst          (rst),
    .div_in       (div_in),
    .rise_pulse   (rise_pulse),
    .fall_pulse   (fall_pulse),
    .period_cnt   (period_cnt),
    .high_cnt     (high_cnt),
    .period_valid (period_valid),
    .lock         (lock),
    .err          (err),
    .stall        (stall)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference model: timestamps of synchronized edges; mode 0 = no reference, 1 = reference seen, 2 = tracking
  int hist[$];
  int cyc, last_rise, mode, streak;
  int m_rp, m_fp, m_pc, m_hc, m_pv, m_lock, m_err, m_stall;

  task automatic model_step();
    int n, y_now, y_prev, span;
    bit r, f;
    if (!rst) begin
      hist.delete();
      cyc = 0; last_rise = 0; mode = 0; streak = 0;
      m_rp = 0; m_fp = 0; m_pc = 0; m_hc = 0; m_pv = 0; m_lock = 0; m_err = 0; m_stall = 0;
    end else begin
      cyc++;
      hist.push_back(int'(div_in));
      if (hist.size() > 4) void'(hist.pop_front());
      n = hist.size();
      y_now  = (n >= 3) ? hist[n-3] : 0;
      y_prev = (n >= 4) ? hist[n-4] : 0;
      r = (y_now != 0) && (y_prev == 0);
      f = (y_now == 0) && (y_prev != 0);
      m_rp = int'(r); m_fp = int'(f); m_pv = 0; m_err = 0;
      span = cyc - last_rise;
      if (span > CMAX) span = CMAX;
      if (f) m_hc = span;
      if (r) begin
        if (mode == 0) begin
          mode = 1;
          m_stall = 0;
        end else begin
          mode = 2;
          m_pc = span;
          m_pv = 1;
          if (span == EXP) begin
            if (streak < LOCKN) streak++;
            if (streak >= LOCKN) m_lock = 1;
          end else begin
            m_err = 1;
            streak = 0;
            m_lock = 0;
          end
        end
        last_rise = cyc;
      end else if (mode != 0 && cyc - last_rise >= CMAX) begin
        if (mode == 2) begin
          m_stall = 1;
          m_lock = 0;
          streak = 0;
        end
        mode = 0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk_in);
    model_step();
  end

  // Per-cycle compare plus event records used by the directed pins
  int ncyc = 0, rp_total = 0, pv_total = 0, err_total = 0, last_rp_cyc = 0;
  int stall_gap = -1, stall_lock = -1, err_pc = -1, err_lock = -1, err_rp = -1, lock_rise_rp = -1;
  int prev_lock = 0, prev_stall = 0;
  int lock_at[NREC], pv_at[NREC], pc_at[NREC], stall_at[NREC];

  initial forever begin
    @(negedge clk_in);
    ncyc++;
    check("rise_pulse",   int'(rise_pulse),   m_rp);
    check("fall_pulse",   int'(fall_pulse),   m_fp);
    check("period_cnt",   int'(period_cnt),   m_pc);
    check("high_cnt",     int'(high_cnt),     m_hc);
    check("period_valid", int'(period_valid), m_pv);
    check("lock",         int'(lock),         m_lock);
    check("err",          int'(err),          m_err);
    check("stall",        int'(stall),        m_stall);
    if (rise_pulse) begin
      rp_total++;
      last_rp_cyc = ncyc;
      if (rp_total < NREC) begin
        lock_at[rp_total]  = int'(lock);
        pv_at[rp_total]    = int'(period_valid);
        pc_at[rp_total]    = int'(period_cnt);
        stall_at[rp_total] = int'(stall);
      end
    end
    if (period_valid) pv_total++;
    if (err) begin
      err_total++;
      err_pc = int'(period_cnt);
      err_lock = int'(lock);
      err_rp = rp_total;
    end
    if (lock && prev_lock == 0) lock_rise_rp = rp_total;
    if (stall && prev_stall == 0) begin
      stall_gap = ncyc - last_rp_cyc;
      stall_lock = int'(lock);
    end
    prev_lock = int'(lock);
    prev_stall = int'(stall);
  end

  task automatic step(input int v);
    div_in = (v != 0);
    @(posedge clk_in);
    #2;
  endtask

  task automatic drive(input int len, input int high);
    for (int i = 0; i < len; i++) step((i < high) ? 1 : 0);
  endtask

  task automatic sync_mon();
    @(negedge clk_in);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rise_pulse"},   int'(rise_pulse),   0);
    check({tag, "_fall_pulse"},   int'(fall_pulse),   0);
    check({tag, "_period_cnt"},   int'(period_cnt),   0);
    check({tag, "_high_cnt"},     int'(high_cnt),     0);
    check({tag, "_period_valid"}, int'(period_valid), 0);
    check({tag, "_lock"},         int'(lock),         0);
    check({tag, "_err"},          int'(err),          0);
    check({tag, "_stall"},        int'(stall),        0);
  endtask

  initial begin
    int b, e0, p0, r, len;
    rst = 1'b0;
    div_in = 1'b0;

    // Reset held while div_in toggles
    repeat (2) drive(5, 2);
    check_all_zero("in_reset");

    // Steady divide-by-5 from a clean release
    rst = 1'b1;
    step(0);
    step(0);
    check("release_quiet", int'(rise_pulse), 0);
    sync_mon();
    b = rp_total;
    e0 = err_total;
    repeat (6) drive(5, 2);
    sync_mon();
    check("steady_rises",   rp_total - b, 6);
    check("steady_pv_r1",   pv_at[b+1], 0);
    check("steady_pv_r2",   pv_at[b+2], 1);
    check("steady_pc_r2",   pc_at[b+2], 5);
    check("steady_lock_r4", lock_at[b+4], 0);
    check("steady_lock_r5", lock_at[b+5], 1);
    check("steady_no_err",  err_total - e0, 0);
    check("steady_high",    int'(high_cnt), 2);

    // One stretched period after lock
    e0 = err_total;
    drive(6, 3);
    repeat (5) drive(5, 2);
    sync_mon();
    check("stretch_err_count", err_total - e0, 1);
    check("stretch_err_pc",    err_pc, 6);
    check("stretch_err_lock",  err_lock, 0);
    check("stretch_relock",    lock_rise_rp - err_rp, 4);
    check("stretch_high",      int'(high_cnt), 2);

    // Stall: div_in held low
    repeat (300) step(0);
    sync_mon();
    check("stall_set",  int'(stall), 1);
    check("stall_gap",  stall_gap, 255);
    check("stall_lock", stall_lock, 0);
    b = rp_total;
    repeat (6) drive(5, 2);
    sync_mon();
    check("stall_clear_r1", stall_at[b+1], 0);
    check("stall_pv_r1",    pv_at[b+1], 0);
    check("stall_pv_r2",    pv_at[b+2], 1);
    check("stall_relocked", int'(lock), 1);

    // One-cycle reset while locked
    rst = 1'b0;
    step(0);
    check_all_zero("rst_mid");
    rst = 1'b1;
    sync_mon();
    b = rp_total;
    repeat (6) drive(5, 2);
    sync_mon();
    check("relock_r4", lock_at[b+4], 0);
    check("relock_r5", lock_at[b+5], 1);

    // div_in already high at reset release
    rst = 1'b0;
    repeat (3) step(1);
    sync_mon();
    b = rp_total;
    e0 = err_total;
    p0 = pv_total;
    rst = 1'b1;
    step(1);
    check("hi_rel_e0", int'(rise_pulse), 0);
    step(1);
    check("hi_rel_e1", int'(rise_pulse), 0);
    step(1);
    check("hi_rel_e2", int'(rise_pulse), 1);
    repeat (7) step(1);
    repeat (10) step(0);
    sync_mon();
    check("hi_rel_rises", rp_total - b, 1);
    check("hi_rel_pv",    pv_total - p0, 0);
    check("hi_rel_err",   err_total - e0, 0);

    // Randomized traffic against the model
    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        rst = 1'b0;
        repeat ($urandom_range(1, 3)) step($urandom_range(0, 1));
        rst = 1'b1;
      end else if (r < 7) begin
        repeat ($urandom_range(240, 300)) step(0);
      end else if (r < 9) begin
        len = $urandom_range(258, 300);
        drive(len, len - $urandom_range(1, 3));
      end else if (r < 60) begin
        drive(5, $urandom_range(2, 3));
      end else begin
        len = $urandom_range(2, 12);
        drive(len, $urandom_range(1, len - 1));
      end
    end

    sync_mon();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
